answer_entry: RTL
=================

# answer_entry

Parametrised digit-entry block for the factorisation game: the player builds an NUM_CH-digit answer with per-channel select buttons, clears or commits it, and the committed answer is offered to the judge over a valid/ready handshake. It also registers the question digits for display and flags question availability. It sits between the debounced switch/button inputs and the judge/display blocks and is gated by the game state bus from the main controller.

## Interface
Parameters:
- NUM_CH, 3: number of answer digit channels.
- DIGIT_W, 4: bits per digit.
- MIN_DIGIT, 1: lowest non-blank digit value.
- MAX_DIGIT, 9: highest digit value; must satisfy 0 < MIN_DIGIT ≤ MAX_DIGIT < 2^DIGIT_W.
- Q_DIGITS, 3: number of question digits.
- REPEAT_CYC, 16: hold cycles per auto-repeat step. Used only with ANSWER_ENTRY_AUTOREPEAT_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- STATE  in  4  game state from the controller.
- SEL  in  NUM_CH  per-channel step buttons, synchronous and debounced.
- DIR  in  1  step direction: 0 increments, 1 decrements.
- CLR  in  1  clears all digits.
- DEC  in  1  commits the current answer.
- QUESTION  in  Q_DIGITS*DIGIT_W  question digits; an all-zero value means no question is present.
- ANS_READY  in  1  judge accepts the answer.
- SEG  out  NUM_CH*DIGIT_W  live entry digits; channel 0 is in the LSBs.
- SEG_Q  out  Q_DIGITS*DIGIT_W  registered question digits.
- ANS  out  NUM_CH*DIGIT_W  committed answer.
- ANS_VALID  out  1  the answer offer is pending.
- DEC_ERR  out  1  one-cycle pulse when a commit is rejected.
- QUE_OK  out  1  a question is present.
- LED  out  1  QUE_OK delayed by one cycle.

## Operation
- INPUT state is STATE==4'b0100.
- Flush states are 0110 (DRAW), 1000 (OUCH), 1001 (GOOD), 1010 (WIN) and 1011 (LOSE).
- Reset values:
  - All outputs are 0.
  - All digit counters are 0 (0 means blank).
  - The FSM is in EDIT.
- Question path:
  - The question register loads QUESTION every cycle, or loads 0 while in a flush state.
  - SEG_Q equals the question register.
  - QUE_OK is registered as (question register != 0).
  - LED is registered from QUE_OK.
- FSM states:
  - EDIT: stepping, clearing and committing are allowed, only while STATE is INPUT.
  - OFFER: ANS_VALID=1; SEL, CLR and DEC are ignored.
  - DONE: the answer has been accepted; all inputs are ignored.
- Transitions:
  - EDIT → OFFER on an accepted DEC.
  - OFFER → DONE when ANS_READY=1 at a clock edge.
  - DONE → EDIT when STATE != INPUT.
  - Any state → EDIT in a flush state.
- Stepping, in EDIT within INPUT:
  - A channel steps on the rising edge of its SEL bit (SEL & ~SEL_d); holding SEL gives no further steps.
  - Every channel with an edge steps in the same cycle. There is no channel priority.
  - Increment from 0 or from MAX_DIGIT gives MIN_DIGIT. Otherwise it gives +1.
  - Decrement from 0 or from MIN_DIGIT gives MAX_DIGIT. Otherwise it gives −1.
- CLR, in EDIT within INPUT:
  - Zeroes all counters.
  - CLR has priority over DEC and over SEL edges in the same cycle.
- DEC, in EDIT within INPUT:
  - Accepted only if all counters are non-zero. ANS is then loaded with the counters as they were before any same-cycle step, and same-cycle SEL edges are discarded.
  - If any counter is 0, DEC_ERR pulses for one cycle and the FSM stays in EDIT.
- Flush state:
  - Counters, ANS, ANS_VALID and the question register clear to 0.
  - A pending offer is aborted. This is the only way ANS_VALID drops without ANS_READY, apart from reset.
- Leaving INPUT to a non-flush state:
  - Counters hold their values.
  - A pending offer stays up until it is accepted.
- SEG always shows the counters.

## Timing
- A SEL rising edge sampled at edge n changes SEG after edge n.
- DEC sampled at edge n: ANS and ANS_VALID are valid after edge n.
- Handshake: ANS is stable while ANS_VALID=1. ANS_VALID drops on the edge following the edge where ANS_READY=1.
- ANS_READY=1 while ANS_VALID=0 has no effect.
- A question appearing at edge n gives SEG_Q after n, QUE_OK after n+1 and LED after n+2.
- Reset assertion clears everything immediately, including mid-offer. The first post-reset cycle sees SEL_d=0, so a button held through reset produces one step.

## Configuration
- ANSWER_ENTRY_AUTOREPEAT_EN defined:
  - A SEL bit held high in EDIT/INPUT produces an extra step every REPEAT_CYC cycles after the initial edge step.
  - Each channel has its own hold counter, reset when its SEL bit goes low.
- Undefined: edge-only stepping; the hold counters are not built.

## Structure
- Package answer_entry_pkg holds:
  - State code localparams: ST_INPUT, ST_DRAW, ST_OUCH, ST_GOOD, ST_WIN, ST_LOSE.
  - An is_flush() function.
  - The FSM enum {EDIT, OFFER, DONE}.
- One sub-module, digit_stepper, instantiated NUM_CH times. It contains:
  - the SEL edge detector;
  - the optional auto-repeat counter;
  - the wrap-around counter, with clear/step/dir inputs.

## Test plan
- Reset, STATE=0100, DIR=0, pulse SEL[0] 10 times → channel 0 steps 1,2,…,9,1. Holding SEL[0] for 5 cycles gives 1 step (macro off).
- DIR=1 on a blank channel 1 → digit becomes 9. Step again → 8. Set channel 2 to 1, then DIR=1 → 9.
- Digits {3,0,5}, DEC → DEC_ERR pulses once, ANS_VALID stays 0. Set the digit to 4, then DEC with SEL[0] high in the same cycle → ANS={5,4,3}, SEG[0] unchanged, ANS_VALID=1.
- ANS_READY held 0 for 4 cycles → ANS_VALID and ANS stay stable, CLR is ignored. ANS_READY=1 → ANS_VALID=0 next cycle, FSM is in DONE, SEL is ignored.
- Mid-offer STATE=1010 → ANS_VALID, ANS, SEG and SEG_Q are 0 next cycle. QUESTION=12'h123 then STATE=0000 → SEG_Q=123, QUE_OK 1 cycle later, LED 1 cycle after that.
- With ANSWER_ENTRY_AUTOREPEAT_EN and REPEAT_CYC=4, hold SEL[1] for 13 cycles → 4 steps (1 edge step + 3 repeats).

Source files
------------

// File: rtl/answer_entry_pkg.sv
// Shared game-state codes, flush-state decode and the entry FSM type for answer_entry.
package answer_entry_pkg;

    localparam logic [3:0] ST_INPUT = 4'b0100;
    localparam logic [3:0] ST_DRAW  = 4'b0110;
    localparam logic [3:0] ST_OUCH  = 4'b1000;
    localparam logic [3:0] ST_GOOD  = 4'b1001;
    localparam logic [3:0] ST_WIN   = 4'b1010;
    localparam logic [3:0] ST_LOSE  = 4'b1011;

    typedef enum logic [1:0] {EDIT, OFFER, DONE} entry_state_t;

    // Round-ending states wipe the entry, the pending answer and the question.
    function automatic logic is_flush(input logic [3:0] state);
        return (state == ST_DRAW) || (state == ST_OUCH) || (state == ST_GOOD) ||
               (state == ST_WIN)  || (state == ST_LOSE);
    endfunction

endpackage

// File: rtl/answer_entry_stepper.sv
// One answer digit: SEL edge detector, wrap-around digit counter and, when
// ANSWER_ENTRY_AUTOREPEAT_EN is defined, a per-channel hold counter for auto-repeat.
module digit_stepper #(
    parameter int DIGIT_W    = 4,
    parameter int MIN_DIGIT  = 1,
    parameter int MAX_DIGIT  = 9,
    parameter int REPEAT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic               dir,
    input  logic               clear,
    input  logic               enable,
    output logic [DIGIT_W-1:0] digit
);

    localparam logic [DIGIT_W-1:0] MIN_V = DIGIT_W'(MIN_DIGIT);
    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX_DIGIT);

    if (MIN_DIGIT < 1 || MIN_DIGIT > MAX_DIGIT || MAX_DIGIT >= (1 << DIGIT_W) || REPEAT_CYC < 1)
    begin : g_bad_param
        $error("digit_stepper: illegal digit range or repeat period");
    end

    logic               sel_d_reg;
    logic               step;
    logic [DIGIT_W-1:0] digit_reg;
    logic [DIGIT_W-1:0] digit_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_d_reg <= 1'b0;
        end else begin
            sel_d_reg <= sel;
        end
    end

`ifdef ANSWER_ENTRY_AUTOREPEAT_EN
    localparam int HOLD_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_CYC - 1);

    logic [HOLD_W-1:0] hold_reg;
    logic              held;
    logic              repeat_hit;

    assign held       = sel & sel_d_reg;
    assign repeat_hit = held && (hold_reg == HOLD_LAST);

    // Counts cycles of continuous hold after the edge; restarts on release or each repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
        end else if (!held || repeat_hit) begin
            hold_reg <= '0;
        end else begin
            hold_reg <= hold_reg + 1'b1;
        end
    end

    assign step = (sel & ~sel_d_reg) | repeat_hit;
`else
    assign step = sel & ~sel_d_reg;
`endif

    always_comb begin
        digit_next = digit_reg;
        if (clear) begin
            digit_next = '0;
        end else if (enable && step) begin
            if (!dir) begin
                digit_next = (digit_reg == '0 || digit_reg == MAX_V) ? MIN_V : digit_reg + 1'b1;
            end else begin
                digit_next = (digit_reg == '0 || digit_reg == MIN_V) ? MAX_V : digit_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_reg <= '0;
        end else begin
            digit_reg <= digit_next;
        end
    end

    assign digit = digit_reg;

endmodule

// File: rtl/answer_entry.sv
// Digit-entry block: per-channel steppers, commit/clear control, answer valid/ready offer
// and question register. Optional auto-repeat via ANSWER_ENTRY_AUTOREPEAT_EN.
module answer_entry
    import answer_entry_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DIGIT_W    = 4,
    parameter int MIN_DIGIT  = 1,
    parameter int MAX_DIGIT  = 9,
    parameter int Q_DIGITS   = 3,
    parameter int REPEAT_CYC = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [3:0]                   STATE,
    input  logic [NUM_CH-1:0]            SEL,
    input  logic                         DIR,
    input  logic                         CLR,
    input  logic                         DEC,
    input  logic [Q_DIGITS*DIGIT_W-1:0]  QUESTION,
    input  logic                         ANS_READY,
    output logic [NUM_CH*DIGIT_W-1:0]    SEG,
    output logic [Q_DIGITS*DIGIT_W-1:0]  SEG_Q,
    output logic [NUM_CH*DIGIT_W-1:0]    ANS,
    output logic                         ANS_VALID,
    output logic                         DEC_ERR,
    output logic                         QUE_OK,
    output logic                         LED
);

    localparam int SEG_W = NUM_CH * DIGIT_W;
    localparam int Q_W   = Q_DIGITS * DIGIT_W;

    entry_state_t     state_reg;
    logic [SEG_W-1:0] digits;
    logic [NUM_CH-1:0] digit_set;
    logic [SEG_W-1:0] ans_reg;
    logic             ans_valid_reg;
    logic             dec_err_reg;
    logic [Q_W-1:0]   question_reg;
    logic             que_ok_reg;
    logic             led_reg;

    logic in_input;
    logic flush;
    logic edit_active;
    logic all_set;
    logic dec_ok;
    logic dec_bad;
    logic clear_digits;
    logic step_enable;

    assign in_input    = (STATE == ST_INPUT);
    assign flush       = is_flush(STATE);
    assign edit_active = (state_reg == EDIT) && in_input;
    assign all_set     = &digit_set;

    // CLR outranks DEC; an accepted DEC freezes the digits so ANS captures the pre-step value.
    assign dec_ok       = edit_active && !CLR && DEC && all_set;
    assign dec_bad      = edit_active && !CLR && DEC && !all_set;
    assign clear_digits = flush || (edit_active && CLR);
    assign step_enable  = edit_active && !dec_ok;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            digit_stepper #(
                .DIGIT_W    (DIGIT_W),
                .MIN_DIGIT  (MIN_DIGIT),
                .MAX_DIGIT  (MAX_DIGIT),
                .REPEAT_CYC (REPEAT_CYC)
            ) u_stepper (
                .clk    (CLK),
                .rst_n  (RST),
                .sel    (SEL[gi]),
                .dir    (DIR),
                .clear  (clear_digits),
                .enable (step_enable),
                .digit  (digits[gi*DIGIT_W +: DIGIT_W])
            );
            assign digit_set[gi] = (digits[gi*DIGIT_W +: DIGIT_W] != '0);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= EDIT;
            ans_reg       <= '0;
            ans_valid_reg <= 1'b0;
            dec_err_reg   <= 1'b0;
        end else begin
            dec_err_reg <= dec_bad;
            if (flush) begin
                state_reg     <= EDIT;
                ans_reg       <= '0;
                ans_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    EDIT: begin
                        if (dec_ok) begin
                            ans_reg       <= digits;
                            ans_valid_reg <= 1'b1;
                            state_reg     <= OFFER;
                        end
                    end
                    OFFER: begin
                        if (ANS_READY) begin
                            ans_valid_reg <= 1'b0;
                            state_reg     <= DONE;
                        end
                    end
                    DONE: begin
                        if (!in_input) begin
                            state_reg <= EDIT;
                        end
                    end
                    default: state_reg <= EDIT;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            question_reg <= '0;
            que_ok_reg   <= 1'b0;
            led_reg      <= 1'b0;
        end else begin
            question_reg <= flush ? '0 : QUESTION;
            que_ok_reg   <= (question_reg != '0);
            led_reg      <= que_ok_reg;
        end
    end

    assign SEG       = digits;
    assign SEG_Q     = question_reg;
    assign ANS       = ans_reg;
    assign ANS_VALID = ans_valid_reg;
    assign DEC_ERR   = dec_err_reg;
    assign QUE_OK    = que_ok_reg;
    assign LED       = led_reg;

endmodule
